// File: rtl/dii_pkt_arbiter_pkg.sv
// dii_pkt_arbiter_pkg: DII flit type and index helper shared by the packet arbiter and its picker
package dii_pkt_arbiter_pkg;
   typedef struct packed {
      logic        valid;
      logic        last;
      logic [15:0] data;
   } dii_flit;
   function automatic int wrap_add(input int base, input int k, input int n);
      return (base + k >= n) ? base + k - n : base + k;
   endfunction
endpackage

// File: rtl/dii_pkt_arbiter_rr_select.sv
// rr_select: combinational round-robin picker returning the first request after ptr
module rr_select
   import dii_pkt_arbiter_pkg::*;
#(
   parameter int PORTS = 4,
   parameter int PW    = $clog2(PORTS)
) (
   input  logic [PORTS-1:0] req,
   input  logic [PW-1:0]    ptr,
   output logic [PW-1:0]    gnt_idx,
   output logic             any
);
   logic [PW-1:0] idx;
   // scan farthest-first so the candidate nearest after ptr is written last and wins
   always_comb begin
      gnt_idx = '0;
      idx     = '0;
      for (int k = PORTS; k >= 1; k--) begin
         idx = PW'(wrap_add(int'(ptr), k, PORTS));
         if (req[idx]) gnt_idx = idx;
      end
   end
   assign any = |req;
endmodule

// File: rtl/dii_pkt_arbiter.sv
// dii_pkt_arbiter: packet-granular round-robin merge of PORTS DII streams onto one output
module dii_pkt_arbiter
   import dii_pkt_arbiter_pkg::*;
#(
   parameter  int PORTS = 4,
   parameter  int CNT_W = 16,
   localparam int PW    = $clog2(PORTS)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  dii_flit [PORTS-1:0]         dii_in,
   output logic [PORTS-1:0]            dii_in_ready,
   output dii_flit                     dii_out,
   input  logic                        dii_out_ready,
   input  logic [PORTS-1:0]            port_enable,
   output logic                        busy,
   output logic [PW-1:0]               grant_id,
   output logic [PORTS-1:0][CNT_W-1:0] pkt_count
);
   typedef enum logic {IDLE, XFER} arb_state_t;
   arb_state_t                  state_q, state_d;
   logic [PW-1:0]               grant_q, grant_d, ptr_q, ptr_d, sel_idx;
   logic [PORTS-1:0]            req;
   logic [PORTS-1:0][CNT_W-1:0] cnt_q;
   logic                        sel_any, done;
   // candidates are only ports that are both offering a flit and enabled
   always_comb begin
      req = '0;
      for (int i = 0; i < PORTS; i++) req[i] = dii_in[i].valid & port_enable[i];
   end
   rr_select #(.PORTS(PORTS)) u_sel (
      .req     (req),
      .ptr     (ptr_q),
      .gnt_idx (sel_idx),
      .any     (sel_any)
   );
   // IDLE picks a winner; XFER passes the granted port through until its last flit transfers
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      ptr_d        = ptr_q;
      done         = 1'b0;
      dii_out      = '0;
      dii_in_ready = '0;
      if (state_q == IDLE) begin
         if (sel_any) begin
            grant_d = sel_idx;
            state_d = XFER;
         end
      end else begin
         dii_out               = dii_in[grant_q];
         dii_in_ready[grant_q] = dii_out_ready;
         done                  = dii_in[grant_q].valid & dii_out_ready & dii_in[grant_q].last;
         if (done) begin
            ptr_d   = grant_q;
            state_d = IDLE;
         end
      end
   end
   // state, grant, priority pointer and per-port completed-packet counters
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         ptr_q   <= PW'(PORTS - 1);
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         if (done) cnt_q[grant_q] <= cnt_q[grant_q] + CNT_W'(1);
      end
   end
   assign busy      = (state_q == XFER);
   assign grant_id  = grant_q;
   assign pkt_count = cnt_q;
endmodule

// File: tb/tb_dii_pkt_arbiter.sv
// tb_dii_pkt_arbiter: scoreboard bench for the packet round-robin arbiter
module tb_dii_pkt_arbiter;
   import dii_pkt_arbiter_pkg::*;
   typedef struct packed {
      logic [1:0]  port;
      logic        last;
      logic [15:0] data;
   } rec_t;
   logic             clk = 1'b0;
   logic             rst = 1'b1;
   dii_flit [3:0]    dii_in;
   logic [3:0]       dii_in_ready;
   dii_flit          dii_out;
   logic             dii_out_ready;
   logic [3:0]       port_enable;
   logic             busy;
   logic [1:0]       grant_id;
   logic [3:0][15:0] pkt_count;
   dii_flit          src [4][$];
   rec_t             exp_q[$];
   rec_t             got_q[$];
   int               exp_cnt[4];
   int               n_checks = 0;
   int               n_fail   = 0;

   always #5 clk = ~clk;

   dii_pkt_arbiter #(.PORTS(4), .CNT_W(16)) dut (
      .clk           (clk),
      .rst           (rst),
      .dii_in        (dii_in),
      .dii_in_ready  (dii_in_ready),
      .dii_out       (dii_out),
      .dii_out_ready (dii_out_ready),
      .port_enable   (port_enable),
      .busy          (busy),
      .grant_id      (grant_id),
      .pkt_count     (pkt_count)
   );

   task automatic refresh();
      for (int p = 0; p < 4; p++) dii_in[p] = (src[p].size() != 0) ? src[p][0] : '0;
   endtask

   task automatic tick();
      logic [3:0] fire;
      fire = '0;
      #1;
      if (!rst && dii_out.valid && dii_out_ready)
         got_q.push_back(rec_t'({grant_id, dii_out.last, dii_out.data}));
      for (int p = 0; p < 4; p++)
         fire[p] = (src[p].size() != 0) && (!dii_in[p].valid || dii_in_ready[p]);
      @(posedge clk);
      #1;
      for (int p = 0; p < 4; p++) if (fire[p]) src[p].delete(0);
      refresh();
      #1;
   endtask

   task automatic push_src(input int p, input logic v, input logic l, input logic [15:0] d);
      src[p].push_back(dii_flit'({v, l, d}));
      refresh();
   endtask

   task automatic send(input int p, input logic [15:0] d, input logic l);
      push_src(p, 1'b1, l, d);
      exp_q.push_back(rec_t'({2'(p), l, d}));
      if (l) exp_cnt[p]++;
   endtask

   task automatic clear_all();
      for (int p = 0; p < 4; p++) begin
         src[p].delete();
         exp_cnt[p] = 0;
      end
      refresh();
   endtask

   task automatic drain();
      for (int i = 0; i < 80 && got_q.size() < exp_q.size(); i++) tick();
      tick();
      tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_all();
      exp_q.delete();
      got_q.delete();
      port_enable   = 4'b1111;
      dii_out_ready = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rec_t g, e;
      rst           = 1'b1;
      port_enable   = 4'b1111;
      dii_out_ready = 1'b1;
      clear_all();
      send(1, 16'h5555, 1'b1);
      send(2, 16'h6666, 1'b1);
      tick();
      tick();
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b expected 0", busy); end
      n_checks++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL reset grant_id: got %0d expected 0", grant_id); end
      n_checks++; if (dii_out.valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b expected 0", dii_out.valid); end
      n_checks++; if (dii_in_ready !== 4'b0000) begin n_fail++; $display("FAIL reset readies: got %b expected 0000", dii_in_ready); end
      n_checks++; if (pkt_count !== '0) begin n_fail++; $display("FAIL reset pkt_count: got %h expected 0", pkt_count); end
      rst = 1'b0;
      tick();
      n_checks++; if (busy !== 1'b1 || grant_id !== 2'd1) begin n_fail++; $display("FAIL reset first_grant: got busy=%b id=%0d expected busy=1 id=1", busy, grant_id); end
      drain();
      while (got_q.size() != 0 && exp_q.size() != 0) begin
         g = got_q.pop_front(); e = exp_q.pop_front();
         n_checks++; if (g !== e) begin n_fail++; $display("FAIL reset flit: got %h expected %h", g, e); end
      end
      n_checks++; if (got_q.size() + exp_q.size() != 0) begin n_fail++; $display("FAIL reset flit_count: got %0d extra expected %0d missing", got_q.size(), exp_q.size()); end
      for (int p = 0; p < 4; p++) begin
         n_checks++; if (pkt_count[p] !== 16'(exp_cnt[p])) begin n_fail++; $display("FAIL reset pkt_count[%0d]: got %0d expected %0d", p, pkt_count[p], exp_cnt[p]); end
      end
   endtask

   task automatic test_single_port();
      rec_t g, e;
      do_reset();
      send(2, 16'h0003, 1'b0);
      send(2, 16'hAAAA, 1'b0);
      send(2, 16'hBBBB, 1'b1);
      n_checks++; if (busy !== 1'b0 || dii_in_ready !== 4'b0000) begin n_fail++; $display("FAIL single pre_grant: got busy=%b rdy=%b expected busy=0 rdy=0000", busy, dii_in_ready); end
      tick();
      n_checks++; if (busy !== 1'b1 || grant_id !== 2'd2) begin n_fail++; $display("FAIL single grant: got busy=%b id=%0d expected busy=1 id=2", busy, grant_id); end
      n_checks++; if (dii_in_ready !== 4'b0100) begin n_fail++; $display("FAIL single ready: got %b expected 0100", dii_in_ready); end
      n_checks++; if (dii_out.data !== 16'h0003 || dii_out.valid !== 1'b1) begin n_fail++; $display("FAIL single first_flit: got v=%b d=%h expected v=1 d=0003", dii_out.valid, dii_out.data); end
      tick(); tick(); tick();
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single busy_after_last: got %b expected 0", busy); end
      while (got_q.size() != 0 && exp_q.size() != 0) begin
         g = got_q.pop_front(); e = exp_q.pop_front();
         n_checks++; if (g !== e) begin n_fail++; $display("FAIL single flit: got %h expected %h", g, e); end
      end
      n_checks++; if (got_q.size() + exp_q.size() != 0) begin n_fail++; $display("FAIL single flit_count: got %0d extra expected %0d missing", got_q.size(), exp_q.size()); end
      for (int p = 0; p < 4; p++) begin
         n_checks++; if (pkt_count[p] !== 16'(exp_cnt[p])) begin n_fail++; $display("FAIL single pkt_count[%0d]: got %0d expected %0d", p, pkt_count[p], exp_cnt[p]); end
      end
   endtask

   task automatic test_round_robin();
      rec_t g, e;
      int   idle;
      do_reset();
      for (int r = 0; r < 2; r++)
         for (int p = 0; p < 4; p++)
            for (int k = 0; k < 2; k++) send(p, 16'(p * 256 + r * 16 + k), k == 1);
      idle = 0;
      for (int i = 0; i < 24; i++) begin
         tick();
         if (!busy) idle++;
      end
      n_checks++; if (idle !== 8) begin n_fail++; $display("FAIL rr idle_cycles: got %0d expected 8", idle); end
      while (got_q.size() != 0 && exp_q.size() != 0) begin
         g = got_q.pop_front(); e = exp_q.pop_front();
         n_checks++; if (g !== e) begin n_fail++; $display("FAIL rr flit: got %h expected %h", g, e); end
      end
      n_checks++; if (got_q.size() + exp_q.size() != 0) begin n_fail++; $display("FAIL rr flit_count: got %0d extra expected %0d missing", got_q.size(), exp_q.size()); end
      for (int p = 0; p < 4; p++) begin
         n_checks++; if (pkt_count[p] !== 16'(exp_cnt[p])) begin n_fail++; $display("FAIL rr pkt_count[%0d]: got %0d expected %0d", p, pkt_count[p], exp_cnt[p]); end
      end
   endtask

   task automatic test_backpressure();
      rec_t g, e;
      do_reset();
      send(1, 16'h1000, 1'b0);
      push_src(1, 1'b0, 1'b0, 16'h0000);
      send(1, 16'h1001, 1'b0);
      send(1, 16'h1002, 1'b0);
      send(1, 16'h1003, 1'b1);
      send(2, 16'h2000, 1'b1);
      send(3, 16'h3000, 1'b1);
      tick();
      n_checks++; if (grant_id !== 2'd1) begin n_fail++; $display("FAIL bp grant: got %0d expected 1", grant_id); end
      for (int i = 0; i < 40 && got_q.size() < 4; i++) begin
         dii_out_ready = (i % 2 == 0);
         #1;
         if (busy && grant_id == 2'd1) begin
            n_checks++; if (dii_in_ready !== (dii_out_ready ? 4'b0010 : 4'b0000)) begin n_fail++; $display("FAIL bp readies: got %b with out_ready=%b", dii_in_ready, dii_out_ready); end
         end
         tick();
      end
      dii_out_ready = 1'b1;
      drain();
      while (got_q.size() != 0 && exp_q.size() != 0) begin
         g = got_q.pop_front(); e = exp_q.pop_front();
         n_checks++; if (g !== e) begin n_fail++; $display("FAIL bp flit: got %h expected %h", g, e); end
      end
      n_checks++; if (got_q.size() + exp_q.size() != 0) begin n_fail++; $display("FAIL bp flit_count: got %0d extra expected %0d missing", got_q.size(), exp_q.size()); end
      for (int p = 0; p < 4; p++) begin
         n_checks++; if (pkt_count[p] !== 16'(exp_cnt[p])) begin n_fail++; $display("FAIL bp pkt_count[%0d]: got %0d expected %0d", p, pkt_count[p], exp_cnt[p]); end
      end
   endtask

   task automatic test_enable();
      rec_t g, e;
      do_reset();
      port_enable = 4'b1110;
      send(1, 16'h1A00, 1'b0);
      send(1, 16'h1A01, 1'b0);
      send(1, 16'h1A02, 1'b1);
      send(0, 16'h0A00, 1'b0);
      send(0, 16'h0A01, 1'b1);
      tick();
      n_checks++; if (busy !== 1'b1 || grant_id !== 2'd1) begin n_fail++; $display("FAIL en grant: got busy=%b id=%0d expected busy=1 id=1", busy, grant_id); end
      port_enable = 4'b1100;
      tick(); tick(); tick();
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL en packet_done: got busy=%b expected 0", busy); end
      tick();
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL en masked_idle: got busy=%b expected 0", busy); end
      n_checks++; if (pkt_count[1] !== 16'd1 || pkt_count[0] !== 16'd0) begin n_fail++; $display("FAIL en counts: got p0=%0d p1=%0d expected p0=0 p1=1", pkt_count[0], pkt_count[1]); end
      port_enable = 4'b1111;
      drain();
      while (got_q.size() != 0 && exp_q.size() != 0) begin
         g = got_q.pop_front(); e = exp_q.pop_front();
         n_checks++; if (g !== e) begin n_fail++; $display("FAIL en flit: got %h expected %h", g, e); end
      end
      n_checks++; if (got_q.size() + exp_q.size() != 0) begin n_fail++; $display("FAIL en flit_count: got %0d extra expected %0d missing", got_q.size(), exp_q.size()); end
      for (int p = 0; p < 4; p++) begin
         n_checks++; if (pkt_count[p] !== 16'(exp_cnt[p])) begin n_fail++; $display("FAIL en pkt_count[%0d]: got %0d expected %0d", p, pkt_count[p], exp_cnt[p]); end
      end
   endtask

   task automatic test_single_flit_wrap();
      rec_t g, e;
      do_reset();
      send(3, 16'h3333, 1'b1);
      tick();
      n_checks++; if (busy !== 1'b1 || grant_id !== 2'd3 || dii_out.last !== 1'b1) begin n_fail++; $display("FAIL sf grant: got busy=%b id=%0d last=%b expected 1/3/1", busy, grant_id, dii_out.last); end
      n_checks++; if (dii_in_ready !== 4'b1000) begin n_fail++; $display("FAIL sf ready: got %b expected 1000", dii_in_ready); end
      tick();
      n_checks++; if (busy !== 1'b0 || pkt_count[3] !== 16'd1) begin n_fail++; $display("FAIL sf done: got busy=%b cnt3=%0d expected busy=0 cnt3=1", busy, pkt_count[3]); end
      send(0, 16'h0A0A, 1'b1);
      send(3, 16'h3B3B, 1'b1);
      tick();
      n_checks++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL sf wrap_grant: got %0d expected 0", grant_id); end
      drain();
      while (got_q.size() != 0 && exp_q.size() != 0) begin
         g = got_q.pop_front(); e = exp_q.pop_front();
         n_checks++; if (g !== e) begin n_fail++; $display("FAIL sf flit: got %h expected %h", g, e); end
      end
      n_checks++; if (got_q.size() + exp_q.size() != 0) begin n_fail++; $display("FAIL sf flit_count: got %0d extra expected %0d missing", got_q.size(), exp_q.size()); end
      for (int p = 0; p < 4; p++) begin
         n_checks++; if (pkt_count[p] !== 16'(exp_cnt[p])) begin n_fail++; $display("FAIL sf pkt_count[%0d]: got %0d expected %0d", p, pkt_count[p], exp_cnt[p]); end
      end
   endtask

   task automatic test_reset_mid_packet();
      rec_t g, e;
      do_reset();
      send(1, 16'h1111, 1'b1);
      tick(); tick();
      n_checks++; if (pkt_count[1] !== 16'd1) begin n_fail++; $display("FAIL rm pre_count: got %0d expected 1", pkt_count[1]); end
      send(0, 16'h0001, 1'b0);
      push_src(0, 1'b1, 1'b0, 16'h0002);
      push_src(0, 1'b1, 1'b1, 16'h0003);
      tick();
      n_checks++; if (busy !== 1'b1 || grant_id !== 2'd0) begin n_fail++; $display("FAIL rm grant: got busy=%b id=%0d expected busy=1 id=0", busy, grant_id); end
      tick();
      n_checks++; if (dii_out.data !== 16'h0002) begin n_fail++; $display("FAIL rm second_flit: got %h expected 0002", dii_out.data); end
      rst = 1'b1;
      clear_all();
      tick();
      n_checks++; if (busy !== 1'b0 || dii_in_ready !== 4'b0000 || dii_out.valid !== 1'b0) begin n_fail++; $display("FAIL rm after_reset: got busy=%b rdy=%b v=%b expected 0/0000/0", busy, dii_in_ready, dii_out.valid); end
      n_checks++; if (pkt_count !== '0) begin n_fail++; $display("FAIL rm counts_cleared: got %h expected 0", pkt_count); end
      rst = 1'b0;
      send(0, 16'h0C0C, 1'b1);
      tick();
      n_checks++; if (busy !== 1'b1 || grant_id !== 2'd0) begin n_fail++; $display("FAIL rm regrant: got busy=%b id=%0d expected busy=1 id=0", busy, grant_id); end
      drain();
      while (got_q.size() != 0 && exp_q.size() != 0) begin
         g = got_q.pop_front(); e = exp_q.pop_front();
         n_checks++; if (g !== e) begin n_fail++; $display("FAIL rm flit: got %h expected %h", g, e); end
      end
      n_checks++; if (got_q.size() + exp_q.size() != 0) begin n_fail++; $display("FAIL rm flit_count: got %0d extra expected %0d missing", got_q.size(), exp_q.size()); end
      for (int p = 0; p < 4; p++) begin
         n_checks++; if (pkt_count[p] !== 16'(exp_cnt[p])) begin n_fail++; $display("FAIL rm pkt_count[%0d]: got %0d expected %0d", p, pkt_count[p], exp_cnt[p]); end
      end
   endtask

   initial begin
      test_reset();
      test_single_port();
      test_round_robin();
      test_backpressure();
      test_enable();
      test_single_flit_wrap();
      test_reset_mid_packet();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
